// File: rtl/add16_pkg.sv
// add16_pkg: shared widths and FSM state type for the shared-adder controller
package add16_pkg;
  localparam int ADD_W = 16;
  localparam int GID_W = 3;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} add16_state_e;
endpackage

// File: rtl/add16_share_ctrl_if.sv
// add16_share_ctrl_if: requester-side operand and result handshakes
interface add16_share_ctrl_if #(parameter int N_REQ = 4);
  import add16_pkg::*;
  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [ADD_W*N_REQ-1:0] req_a;
  logic [ADD_W*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]       rsp_valid;
  logic [N_REQ-1:0]       rsp_ready;
  logic [ADD_W-1:0]       rsp_sum;
  modport master (output req_valid, req_a, req_b, rsp_ready, input req_ready, rsp_valid, rsp_sum);
  modport slave  (input req_valid, req_a, req_b, rsp_ready, output req_ready, rsp_valid, rsp_sum);
endinterface

// File: rtl/add16_rr_pick.sv
// add16_rr_pick: first valid requester searching circularly from rr_ptr
module add16_rr_pick import add16_pkg::*; #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_valid,
  input  logic [GID_W-1:0] rr_ptr,
  output logic [N_REQ-1:0] pick,
  output logic [GID_W-1:0] pick_id,
  output logic             any
);
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  always_comb begin
    dbl = {req_valid, req_valid} >> rr_ptr;
    rot = dbl[N_REQ-1:0];
    pick_id = '0;
    for (int k = N_REQ - 1; k >= 0; k--)
      if (rot[k]) pick_id = GID_W'((int'(rr_ptr) + k) % N_REQ);
    any = |req_valid;
    pick = any ? N_REQ'(1) << pick_id : '0;
  end
endmodule

// File: rtl/add16_share_ctrl.sv
// add16_share_ctrl: round-robin sharing of one registered 16-bit adder
module add16_share_ctrl import add16_pkg::*; #(
  parameter int N_REQ   = 4,
  parameter int ADD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  add16_share_ctrl_if.slave bus,
  output logic [ADD_W-1:0] add_a,
  output logic [ADD_W-1:0] add_b,
  input  logic [ADD_W-1:0] add_sum,
  output logic             busy,
  output logic [GID_W-1:0] grant_id
);
  add16_state_e     state, state_d;
  logic [GID_W-1:0] rr_ptr, pick_id;
  logic [3:0]       lat_cnt;
  logic [N_REQ-1:0] pick, rsp_valid;
  logic [ADD_W-1:0] rsp_sum;
  logic             any, rsp_hit;
  add16_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_valid(bus.req_valid),
    .rr_ptr(rr_ptr),
    .pick(pick),
    .pick_id(pick_id),
    .any(any)
  );
  always_comb begin
    rsp_hit = |(bus.rsp_ready & rsp_valid);
    state_d = (state == IDLE && any)           ? WAIT :
              (state == WAIT && lat_cnt == '0) ? RESP :
              (state == RESP && rsp_hit)       ? IDLE : state;
  end
  // gated by rst_n so a held reset never advertises a grant
  assign bus.req_ready = (state == IDLE && rst_n) ? pick : '0;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_sum   = rsp_sum;
  assign busy          = state != IDLE;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      lat_cnt   <= '0;
      add_a     <= '0;
      add_b     <= '0;
      grant_id  <= '0;
      rsp_sum   <= '0;
      rsp_valid <= '0;
    end else begin
      state <= state_d;
      if (state == IDLE && any) begin
        add_a    <= ADD_W'(bus.req_a >> (pick_id * ADD_W));
        add_b    <= ADD_W'(bus.req_b >> (pick_id * ADD_W));
        grant_id <= pick_id;
        lat_cnt  <= 4'(ADD_LAT - 1);
      end else if (state == WAIT && lat_cnt == '0) begin
        rsp_sum   <= add_sum;
        rsp_valid <= N_REQ'(1) << grant_id;
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
      end else if (state == RESP && rsp_hit) begin
        rsp_valid <= '0;
        rr_ptr    <= (int'(grant_id) == N_REQ - 1) ? '0 : grant_id + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_add16_share_ctrl.sv
// tb_add16_share_ctrl: randomized checks of the shared-adder controller at ADD_LAT 1 and 3
module tb_add16_share_ctrl;
  localparam int N = 4;
  logic clk = 0;
  logic rst_n = 0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int passed = 0;
  int total = 0;
  add16_share_ctrl_if #(.N_REQ(N)) if1 ();
  add16_share_ctrl_if #(.N_REQ(N)) if3 ();
  logic [15:0] a1, b1, s1, a3, b3, s3, p0, p1;
  logic busy1, busy3;
  logic [2:0] g1, g3;
  add16_share_ctrl #(.N_REQ(N), .ADD_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave),
    .add_a(a1), .add_b(b1), .add_sum(s1), .busy(busy1), .grant_id(g1)
  );
  add16_share_ctrl #(.N_REQ(N), .ADD_LAT(3)) u3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave),
    .add_a(a3), .add_b(b3), .add_sum(s3), .busy(busy3), .grant_id(g3)
  );
  // adder sources: combinational behind registered operands, and a two-stage pipelined one
  assign s1 = a1 + b1;
  always @(posedge clk) begin
    p0 <= a3 + b3;
    p1 <= p0;
  end
  assign s3 = p1;
  logic [15:0] opa1[N], opb1[N], opa3[N], opb3[N];
  int ptr1 = 0;
  int ptr3 = 0;
  function automatic int pick_m(input logic [N-1:0] m, input int p);
    for (int k = 0; k < N; k++) if (m[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction
  task automatic set_ops1;
    for (int i = 0; i < N; i++) begin
      if1.req_a[16*i +: 16] = opa1[i];
      if1.req_b[16*i +: 16] = opb1[i];
    end
  endtask
  task automatic set_ops3;
    for (int i = 0; i < N; i++) begin
      if3.req_a[16*i +: 16] = opa3[i];
      if3.req_b[16*i +: 16] = opb3[i];
    end
  endtask
  task automatic test_reset;
    if1.req_valid = 4'hF;
    repeat (3) @(negedge clk);
    #1;
    total++; if (if1.req_ready !== 4'h0) $display("FAIL reset_req_ready got %h want 0", if1.req_ready); else passed++;
    total++; if ({if1.rsp_valid, busy1, g1} !== 8'h0) $display("FAIL reset_ctrl got %h want 0", {if1.rsp_valid, busy1, g1}); else passed++;
    total++; if ({a1, b1, if1.rsp_sum} !== 48'h0) $display("FAIL reset_data got %h want 0", {a1, b1, if1.rsp_sum}); else passed++;
    total++; if ({if3.rsp_valid, busy3, g3, if3.req_ready} !== 12'h0) $display("FAIL reset_lat3 got %h want 0", {if3.rsp_valid, busy3, g3, if3.req_ready}); else passed++;
    if1.req_valid = 0;
    @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_single;
    int acc;
    @(negedge clk);
    opa1[2] = 2; opb1[2] = 4; set_ops1;
    if1.rsp_ready = 4'hF;
    if1.req_valid = 4'b0100;
    #1;
    total++; if (if1.req_ready !== 4'b0100) $display("FAIL single_ready got %b want 0100", if1.req_ready); else passed++;
    acc = cyc;
    @(negedge clk);
    if1.req_valid = 0;
    #1;
    total++; if ({if1.req_ready, busy1, g1, a1, b1} !== {4'b0, 1'b1, 3'd2, 16'd2, 16'd4}) $display("FAIL single_wait got %h want %h", {if1.req_ready, busy1, g1, a1, b1}, {4'b0, 1'b1, 3'd2, 16'd2, 16'd4}); else passed++;
    for (int k = 0; k < 40 && if1.rsp_valid == 0; k++) begin @(negedge clk); #1; end
    total++; if (if1.rsp_valid !== 4'b0100 || if1.rsp_sum !== 16'd6) $display("FAIL single_rsp got %b/%0d want 0100/6", if1.rsp_valid, if1.rsp_sum); else passed++;
    total++; if (cyc - acc !== 2) $display("FAIL single_latency got %0d want 2", cyc - acc); else passed++;
    @(negedge clk); #1;
    total++; if (if1.rsp_valid !== 4'b0 || busy1 !== 1'b0) $display("FAIL single_done got %b/%b want 0000/0", if1.rsp_valid, busy1); else passed++;
    ptr1 = 3;
  endtask
  task automatic test_wrap;
    int exp;
    @(negedge clk);
    opa1[0] = 16'd34952; opb1[0] = 16'd34952; set_ops1;
    if1.req_valid = 4'b0001;
    #1;
    exp = pick_m(4'b0001, ptr1);
    total++; if (if1.req_ready !== 4'(1 << exp)) $display("FAIL wrap_ready got %b want %b", if1.req_ready, 4'(1 << exp)); else passed++;
    @(negedge clk);
    if1.req_valid = 0;
    for (int k = 0; k < 40 && if1.rsp_valid == 0; k++) begin @(negedge clk); #1; end
    total++; if (if1.rsp_sum !== 16'd4368 || g1 !== 3'd0) $display("FAIL wrap_sum got %0d/%0d want 4368/0", if1.rsp_sum, g1); else passed++;
    @(negedge clk);
    ptr1 = 1;
  endtask
  task automatic test_reset_mid;
    int exp;
    @(negedge clk);
    opa1[2] = 100; opb1[2] = 200; set_ops1;
    if1.req_valid = 4'b0100;
    #1;
    exp = pick_m(4'b0100, ptr1);
    total++; if (if1.req_ready !== 4'(1 << exp)) $display("FAIL rmid_ready got %b want %b", if1.req_ready, 4'(1 << exp)); else passed++;
    @(negedge clk); #1;
    total++; if (busy1 !== 1'b1) $display("FAIL rmid_busy got %b want 1", busy1); else passed++;
    rst_n = 0;
    if1.req_valid = 4'hF;
    #1;
    total++; if ({if1.req_ready, if1.rsp_valid, busy1, g1} !== 12'h0) $display("FAIL rmid_ctrl got %h want 0", {if1.req_ready, if1.rsp_valid, busy1, g1}); else passed++;
    total++; if ({a1, b1, if1.rsp_sum} !== 48'h0) $display("FAIL rmid_data got %h want 0", {a1, b1, if1.rsp_sum}); else passed++;
    @(negedge clk);
    rst_n = 1;
    ptr1 = 0;
    #1;
    exp = pick_m(4'hF, ptr1);
    total++; if (if1.req_ready !== 4'(1 << exp)) $display("FAIL rmid_after got %b want %b", if1.req_ready, 4'(1 << exp)); else passed++;
    if1.req_valid = 0;
  endtask
  task automatic test_rotate;
    int exp, acc, last;
    logic [15:0] ea, eb;
    last = 0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin opa1[i] = 16'($urandom); opb1[i] = 16'($urandom); end
    set_ops1;
    if1.rsp_ready = 4'hF;
    if1.req_valid = 4'hF;
    #1;
    for (int g = 0; g < 6; g++) begin
      for (int k = 0; k < 40 && if1.req_ready == 0; k++) begin @(negedge clk); #1; end
      exp = pick_m(4'hF, ptr1);
      total++; if (if1.req_ready !== 4'(1 << exp)) $display("FAIL rot_grant%0d got %b want %b", g, if1.req_ready, 4'(1 << exp)); else passed++;
      acc = cyc;
      if (g > 0) begin
        total++; if (acc - last !== 3) $display("FAIL rot_spacing%0d got %0d want 3", g, acc - last); else passed++;
      end
      last = acc;
      ea = opa1[exp]; eb = opb1[exp];
      @(negedge clk);
      opa1[exp] = 16'($urandom); opb1[exp] = 16'($urandom); set_ops1;
      #1;
      for (int k = 0; k < 40 && if1.rsp_valid == 0; k++) begin @(negedge clk); #1; end
      total++; if (if1.rsp_valid !== 4'(1 << exp) || if1.rsp_sum !== 16'(ea + eb)) $display("FAIL rot_rsp%0d got %b/%h want %b/%h", g, if1.rsp_valid, if1.rsp_sum, 4'(1 << exp), 16'(ea + eb)); else passed++;
      total++; if (cyc - acc !== 2) $display("FAIL rot_latency%0d got %0d want 2", g, cyc - acc); else passed++;
      ptr1 = (exp + 1) % N;
    end
    if1.req_valid = 0;
    @(negedge clk);
  endtask
  task automatic test_backpressure;
    int exp;
    logic [15:0] es;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin opa1[i] = 16'($urandom); opb1[i] = 16'($urandom); end
    set_ops1;
    if1.rsp_ready = 4'b1101;
    if1.req_valid = 4'b0010;
    #1;
    exp = pick_m(4'b0010, ptr1);
    es = 16'(opa1[exp] + opb1[exp]);
    total++; if (if1.req_ready !== 4'(1 << exp)) $display("FAIL bp_ready got %b want %b", if1.req_ready, 4'(1 << exp)); else passed++;
    @(negedge clk);
    if1.req_valid = 4'hF;
    #1;
    for (int k = 0; k < 40 && if1.rsp_valid == 0; k++) begin @(negedge clk); #1; end
    for (int h = 0; h < 5; h++) begin
      total++; if ({if1.rsp_valid, if1.rsp_sum, busy1, if1.req_ready, g1} !== {4'(1 << exp), es, 1'b1, 4'b0, 3'(exp)}) $display("FAIL bp_hold%0d got %h want %h", h, {if1.rsp_valid, if1.rsp_sum, busy1, if1.req_ready, g1}, {4'(1 << exp), es, 1'b1, 4'b0, 3'(exp)}); else passed++;
      @(negedge clk); #1;
    end
    if1.req_valid = 0;
    if1.rsp_ready = 4'hF;
    @(negedge clk); #1;
    total++; if (busy1 !== 1'b0 || if1.rsp_valid !== 4'b0) $display("FAIL bp_release got %b/%b want 0/0000", busy1, if1.rsp_valid); else passed++;
    ptr1 = (exp + 1) % N;
  endtask
  task automatic test_lat3;
    int exp, acc;
    logic [N-1:0] mask;
    logic [15:0] es;
    if3.rsp_ready = 4'hF;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin opa3[i] = 16'($urandom_range(0, 9999)); opb3[i] = 16'($urandom_range(0, 19999)); end
      set_ops3;
      if3.req_valid = mask;
      #1;
      exp = pick_m(mask, ptr3);
      es = 16'((int'(opa3[exp]) + int'(opb3[exp])) % 65536);
      total++; if (if3.req_ready !== 4'(1 << exp)) $display("FAIL l3_ready%0d got %b want %b", n, if3.req_ready, 4'(1 << exp)); else passed++;
      acc = cyc;
      @(negedge clk);
      if3.req_valid = 0;
      #1;
      total++; if (g3 !== 3'(exp)) $display("FAIL l3_grant%0d got %0d want %0d", n, g3, exp); else passed++;
      for (int k = 0; k < 40 && if3.rsp_valid == 0; k++) begin @(negedge clk); #1; end
      total++; if (if3.rsp_valid !== 4'(1 << exp) || if3.rsp_sum !== es) $display("FAIL l3_rsp%0d got %b/%0d want %b/%0d", n, if3.rsp_valid, if3.rsp_sum, 4'(1 << exp), es); else passed++;
      total++; if (cyc - acc !== 4) $display("FAIL l3_latency%0d got %0d want 4", n, cyc - acc); else passed++;
      ptr3 = (exp + 1) % N;
    end
    @(negedge clk);
  endtask
  initial begin
    if1.req_valid = 0; if1.req_a = 0; if1.req_b = 0; if1.rsp_ready = 0;
    if3.req_valid = 0; if3.req_a = 0; if3.req_b = 0; if3.rsp_ready = 0;
    test_reset;
    test_single;
    test_wrap;
    test_reset_mid;
    test_rotate;
    test_backpressure;
    test_lat3;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
